// File: rtl/conv3x3_filter.sv
// Sliding 3x3 RGB565 window over a three-row column stream with a runtime-selectable kernel.
// Three register stages: window shift, per-channel partial sums, kernel/clamp/border mux.
module conv3x3_filter #(
  parameter int unsigned HRES = 1280,
  parameter int unsigned VRES = 720
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [2:0][15:0] column_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             data_valid_in,
  input  logic [1:0]       filter_sel_in,
  output logic [15:0]      pixel_out,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out,
  output logic             data_valid_out
);

  localparam logic [10:0] HLast = 11'(HRES - 1);
  localparam logic [9:0]  VLast = 10'(VRES - 1);

  // Channel 0 = R [15:11], 1 = G [10:5], 2 = B [4:0]; zero-extended to 6 bits.
  function automatic logic [5:0] chan(input logic [15:0] pix, input int unsigned idx);
    case (idx)
      0:       chan = {1'b0, pix[15:11]};
      1:       chan = pix[10:5];
      default: chan = {1'b0, pix[4:0]};
    endcase
  endfunction

  function automatic logic [5:0] kernel(input logic [1:0] sel, input logic [5:0] c,
                                        input logic [9:0] n, input logic [9:0] d,
                                        input logic [5:0] m);
    logic signed [11:0] cs, ns, ds, ms, t;
    cs = $signed({6'd0, c});
    ns = $signed({2'd0, n});
    ds = $signed({2'd0, d});
    ms = $signed({6'd0, m});
    case (sel)
      2'd1:    t = ((cs <<< 2) + (ns <<< 1) + ds) >>> 4;
      2'd2:    t = (cs <<< 2) + cs - ns;
      2'd3: begin
        t = (cs <<< 2) - ns;
        if (t[11]) t = -t;
      end
      default: t = cs;
    endcase
    if (t[11])       kernel = '0;
    else if (t > ms) kernel = m;
    else             kernel = t[5:0];
  endfunction

  // Stage 1: window shift
  logic [2:0][15:0] col_l_q, col_c_q, col_r_q;
  logic [10:0]      hc_c_q, hc_r_q;
  logic [9:0]       vc_c_q, vc_r_q;
  logic [1:0]       sel1_q;
  logic [1:0]       prime_q;
  logic             valid1_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      col_l_q  <= '0;
      col_c_q  <= '0;
      col_r_q  <= '0;
      hc_c_q   <= '0;
      hc_r_q   <= '0;
      vc_c_q   <= '0;
      vc_r_q   <= '0;
      sel1_q   <= '0;
      prime_q  <= '0;
      valid1_q <= 1'b0;
    end else begin
      // The window is complete only once two earlier columns are already held.
      valid1_q <= data_valid_in && (prime_q == 2'd2);
      if (data_valid_in) begin
        col_l_q <= col_c_q;
        col_c_q <= col_r_q;
        col_r_q <= column_in;
        hc_c_q  <= hc_r_q;
        vc_c_q  <= vc_r_q;
        hc_r_q  <= hcount_in;
        vc_r_q  <= vcount_in;
        sel1_q  <= filter_sel_in;
        if (prime_q != 2'd2) prime_q <= prime_q + 2'd1;
      end
    end
  end

  // Stage 2: partial sums per channel
  logic [9:0] n_sum [3];
  logic [9:0] d_sum [3];
  logic       border1;

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      n_sum[i] = 10'(chan(col_c_q[0], i)) + 10'(chan(col_c_q[2], i)) +
                 10'(chan(col_l_q[1], i)) + 10'(chan(col_r_q[1], i));
      d_sum[i] = 10'(chan(col_l_q[0], i)) + 10'(chan(col_l_q[2], i)) +
                 10'(chan(col_r_q[0], i)) + 10'(chan(col_r_q[2], i));
    end
    border1 = (hc_c_q == '0) || (hc_c_q == HLast) || (vc_c_q == '0) || (vc_c_q == VLast);
  end

  logic [9:0]  n2_q [3];
  logic [9:0]  d2_q [3];
  logic [15:0] pix2_q;
  logic [10:0] hc2_q;
  logic [9:0]  vc2_q;
  logic [1:0]  sel2_q;
  logic        border2_q;
  logic        valid2_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 3; i++) begin
        n2_q[i] <= '0;
        d2_q[i] <= '0;
      end
      pix2_q    <= '0;
      hc2_q     <= '0;
      vc2_q     <= '0;
      sel2_q    <= '0;
      border2_q <= 1'b0;
      valid2_q  <= 1'b0;
    end else begin
      valid2_q <= valid1_q;
      if (valid1_q) begin
        for (int i = 0; i < 3; i++) begin
          n2_q[i] <= n_sum[i];
          d2_q[i] <= d_sum[i];
        end
        pix2_q    <= col_c_q[1];
        hc2_q     <= hc_c_q;
        vc2_q     <= vc_c_q;
        sel2_q    <= sel1_q;
        border2_q <= border1;
      end
    end
  end

  // Stage 3: kernel, clamp, border mux
  logic [5:0]  res [3];
  logic [15:0] filt;
  logic [15:0] pix3_d;

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      res[i] = kernel(sel2_q, chan(pix2_q, i), n2_q[i], d2_q[i], (i == 1) ? 6'd63 : 6'd31);
    end
    filt   = ({10'd0, res[0]} << 11) | ({10'd0, res[1]} << 5) | {10'd0, res[2]};
    pix3_d = border2_q ? pix2_q : filt;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pixel_out      <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= valid2_q;
      if (valid2_q) begin
        pixel_out  <= pix3_d;
        hcount_out <= hc2_q;
        vcount_out <= vc2_q;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_filter.sv
// Bench for conv3x3_filter at 8x4: reference model built from a history of sent columns,
// hand-computed window vectors, and wrap / mid-line reset sequences.
module tb_conv3x3_filter;

  localparam int HRES = 8;
  localparam int VRES = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0][15:0] col_in = '0;
  logic [10:0]      hc_in = '0;
  logic [9:0]       vc_in = '0;
  logic             dv_in = 1'b0;
  logic [1:0]       sel_in = '0;
  logic [15:0]      pix_o;
  logic [10:0]      hc_o;
  logic [9:0]       vc_o;
  logic             dv_o;

  conv3x3_filter #(.HRES(HRES), .VRES(VRES)) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .column_in      (col_in),
    .hcount_in      (hc_in),
    .vcount_in      (vc_in),
    .data_valid_in  (dv_in),
    .filter_sel_in  (sel_in),
    .pixel_out      (pix_o),
    .hcount_out     (hc_o),
    .vcount_out     (vc_o),
    .data_valid_out (dv_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0][15:0] col;
    int               h;
    int               v;
    logic [1:0]       sel;
  } col_t;

  typedef struct {
    logic        v;
    logic [15:0] pix;
    int          hc;
    int          vc;
  } exp_t;

  typedef struct {
    logic [1:0]  sel;
    int          v;
    logic [15:0] l;
    logic [15:0] ct;
    logic [15:0] cm;
    logic [15:0] r;
    logic [15:0] exp;
  } vec_t;

  col_t        hist[$];
  exp_t        pipe[3];
  vec_t        tbl[13];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_out = 0;
  logic [15:0] last_pix = '0;
  int          last_hc = 0;
  int          last_vc = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int chan(input logic [15:0] p, input int i);
    int w;
    w = int'(p);
    case (i)
      0:       return (w >> 11) & 31;
      1:       return (w >> 5) & 63;
      default: return w & 31;
    endcase
  endfunction

  // Reference: arithmetic straight from the kernel definitions on the three sent columns.
  function automatic logic [15:0] ref_pix(input col_t l, input col_t c, input col_t r);
    int cc, n, d, x, m, s;
    int res[3];
    if (c.h == 0 || c.h == HRES - 1 || c.v == 0 || c.v == VRES - 1) return c.col[1];
    s = int'(r.sel);
    for (int i = 0; i < 3; i++) begin
      m  = (i == 1) ? 63 : 31;
      cc = chan(c.col[1], i);
      n  = chan(c.col[0], i) + chan(c.col[2], i) + chan(l.col[1], i) + chan(r.col[1], i);
      d  = chan(l.col[0], i) + chan(l.col[2], i) + chan(r.col[0], i) + chan(r.col[2], i);
      case (s)
        0:       x = cc;
        1:       x = (4 * cc + 2 * n + d) / 16;
        2:       x = 5 * cc - n;
        default: begin
          x = 4 * cc - n;
          if (x < 0) x = -x;
        end
      endcase
      if (x < 0) x = 0;
      if (x > m) x = m;
      res[i] = x;
    end
    return 16'((res[0] << 11) | (res[1] << 5) | res[2]);
  endfunction

  function automatic logic [2:0][15:0] mkcol(input logic [15:0] top, input logic [15:0] mid,
                                             input logic [15:0] bot);
    logic [2:0][15:0] c;
    c[0] = top;
    c[1] = mid;
    c[2] = bot;
    return c;
  endfunction

  function automatic logic [15:0] rndpix();
    logic [15:0] p;
    p = 16'($urandom);
    if ($urandom_range(1) == 0) p = p & 16'h18C3;
    return p;
  endfunction

  function automatic logic [2:0][15:0] rndcol();
    return mkcol(rndpix(), rndpix(), rndpix());
  endfunction

  // One cycle: check the output due now, then drive this cycle's input.
  task automatic step(input logic valid, input logic [2:0][15:0] col, input int h, input int v,
                      input logic [1:0] s);
    exp_t e;
    col_t ce;
    @(negedge clk);
    cmp("valid", 32'(dv_o), 32'(pipe[2].v));
    if (pipe[2].v) begin
      cmp("pixel", 32'(pix_o), 32'(pipe[2].pix));
      cmp("hcount", 32'(hc_o), 32'(pipe[2].hc));
      cmp("vcount", 32'(vc_o), 32'(pipe[2].vc));
    end
    if (dv_o) begin
      n_out++;
      last_pix = pix_o;
      last_hc  = int'(hc_o);
      last_vc  = int'(vc_o);
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    e.v = 1'b0; e.pix = '0; e.hc = 0; e.vc = 0;
    col_in = col;
    hc_in  = 11'(h);
    vc_in  = 10'(v);
    dv_in  = valid;
    sel_in = s;
    if (valid) begin
      ce.col = col; ce.h = h; ce.v = v; ce.sel = s;
      hist.push_back(ce);
      if (hist.size() > 3) hist.delete(0);
      if (hist.size() == 3) begin
        e.v   = 1'b1;
        e.pix = ref_pix(hist[0], hist[1], hist[2]);
        e.hc  = hist[1].h;
        e.vc  = hist[1].v;
      end
    end
    pipe[0] = e;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 0, 0, 2'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dv_in = 1'b0;
    #1;
    cmp("rst_pixel", 32'(pix_o), 32'd0);
    cmp("rst_hcount", 32'(hc_o), 32'd0);
    cmp("rst_vcount", 32'(vc_o), 32'd0);
    cmp("rst_valid", 32'(dv_o), 32'd0);
    hist.delete();
    for (int k = 0; k < 3; k++) pipe[k] = '{1'b0, 16'd0, 0, 0};
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] saved;
    int          base;

    tbl[0]  = '{2'd1, 1, 16'h8410, 16'h8410, 16'h8410, 16'h8410, 16'h8410};
    tbl[1]  = '{2'd2, 1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    tbl[2]  = '{2'd2, 1, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    tbl[3]  = '{2'd2, 1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[4]  = '{2'd3, 1, 16'h0000, 16'h0841, 16'h0841, 16'h0841, 16'h0841};
    tbl[5]  = '{2'd3, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0841, 16'h0841};
    tbl[6]  = '{2'd3, 1, 16'h0841, 16'h0841, 16'h0841, 16'h0841, 16'h0000};
    tbl[7]  = '{2'd0, 1, 16'hFFFF, 16'h0000, 16'hA5A5, 16'h1111, 16'hA5A5};
    tbl[8]  = '{2'd3, 1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    tbl[9]  = '{2'd1, 1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h39E7};
    tbl[10] = '{2'd2, 1, 16'h0000, 16'h0000, 16'h0841, 16'h0000, 16'h2945};
    tbl[11] = '{2'd3, 0, 16'hFFFF, 16'hFFFF, 16'h1234, 16'hFFFF, 16'h1234};
    tbl[12] = '{2'd2, 3, 16'hFFFF, 16'hFFFF, 16'h1234, 16'hFFFF, 16'h1234};

    for (int k = 0; k < 3; k++) pipe[k] = '{1'b0, 16'd0, 0, 0};

    repeat (2) @(negedge clk);
    cmp("reset_pixel", 32'(pix_o), 32'd0);
    cmp("reset_hcount", 32'(hc_o), 32'd0);
    cmp("reset_vcount", 32'(vc_o), 32'd0);
    cmp("reset_valid", 32'(dv_o), 32'd0);
    rst_n = 1'b1;

    // Identity ramp on the centre row, back-to-back
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++)
        step(1'b1, mkcol(rndpix(), 16'((h << 11) | (h << 5) | h), rndpix()), h, v, 2'd0);

    // Random frames, random selects, random gaps
    for (int f = 0; f < 4; f++)
      for (int v = 0; v < VRES; v++)
        for (int h = 0; h < HRES; h++) begin
          if ($urandom_range(3) == 0) idle(int'($urandom_range(2)) + 1);
          step(1'b1, rndcol(), h, v, 2'($urandom_range(3)));
        end
    idle(3);

    // Hand-computed windows centred on column 3
    for (int i = 0; i < 13; i++) begin
      step(1'b1, mkcol(tbl[i].l, tbl[i].l, tbl[i].l), 2, tbl[i].v, tbl[i].sel);
      step(1'b1, mkcol(tbl[i].ct, tbl[i].cm, tbl[i].ct), 3, tbl[i].v, tbl[i].sel);
      step(1'b1, mkcol(tbl[i].r, tbl[i].r, tbl[i].r), 4, tbl[i].v, tbl[i].sel);
      idle(3);
      cmp($sformatf("tbl%0d_pixel", i), 32'(last_pix), 32'(tbl[i].exp));
      cmp($sformatf("tbl%0d_hcount", i), 32'(last_hc), 32'd3);
      cmp($sformatf("tbl%0d_vcount", i), 32'(last_vc), 32'(tbl[i].v));
    end

    // Line wrap: column 0 of line 2 completes the last pixel of line 1
    saved = '0;
    for (int h = 0; h < HRES; h++) begin
      col_t tmp;
      tmp.col = rndcol();
      if (h == HRES - 1) saved = tmp.col[1];
      step(1'b1, tmp.col, h, 1, 2'd3);
    end
    step(1'b1, rndcol(), 0, 2, 2'd3);
    idle(3);
    cmp("wrap_hcount", 32'(last_hc), 32'(HRES - 1));
    cmp("wrap_vcount", 32'(last_vc), 32'd1);
    cmp("wrap_pixel", 32'(last_pix), 32'(saved));

    // Mid-line reset: re-prime on the next two columns
    for (int h = 0; h < 4; h++) step(1'b1, rndcol(), h, 1, 2'd0);
    pulse_reset();
    base = n_out;
    for (int h = 4; h < HRES; h++) step(1'b1, rndcol(), h, 1, 2'd0);
    idle(3);
    cmp("rst_outputs", 32'(n_out - base), 32'd2);
    cmp("rst_last_hcount", 32'(last_hc), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv3x3_filter.md
# conv3x3_filter

Consumes the three-row column stream produced by the line buffer and assembles a sliding 3x3 RGB565 window from it. Applies a runtime-selectable 3x3 kernel: identity, Gaussian blur, sharpen or Laplacian edge. Emits one filtered pixel per valid input column, with matching hcount/vcount/valid, for the downstream frame-buffer or threshold stage. Frame-border pixels pass through unfiltered.

## Interface
- HRES, 1280: active pixels per line.
- VRES, 720: active lines per frame.
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- column_in  input  3x16  RGB565 column. [0] = top row, [1] = centre row, [2] = bottom row.
- hcount_in  input  11  column index of column_in.
- vcount_in  input  10  row index of the centre row, column_in[1].
- data_valid_in  input  1  column_in, hcount_in and vcount_in are valid this cycle.
- filter_sel_in  input  2  kernel select: 0 identity, 1 Gaussian, 2 sharpen, 3 edge.
- pixel_out  output  16  filtered RGB565 pixel.
- hcount_out  output  11  column of pixel_out.
- vcount_out  output  10  row of pixel_out.
- data_valid_out  output  1  pixel_out, hcount_out and vcount_out are valid.

## Operation
- **Window.** Three column registers L, C, R, each 3x16. On data_valid_in: L<=C, C<=R, R<=column_in. Each register has companion hcount/vcount registers. When data_valid_in is low, everything holds.
- **Centre pixel.** Column h arriving completes the window for centre column h-1.
  - At h=0, the centre is column HRES-1 of the previous line.
  - In that case hcount_out=HRES-1 and vcount_out is the previous centre vcount.
- **Priming.** data_valid_out stays suppressed until two valid columns have been captured after reset. Exactly one output is produced per valid input column after that.
- **Border rule.** If centre hcount is 0 or HRES-1, or centre vcount is 0 or VRES-1, pixel_out = the unfiltered centre pixel, regardless of filter_sel_in.
- **Kernel select.** filter_sel_in is sampled with the window shift and pipelined alongside the data, so each pixel uses the select present when its right column arrived.
- **Arithmetic.** Done per channel, independently: R 5 bits, G 6 bits, B 5 bits, with channel max M = 31 or 63. c = centre, n = sum of the 4 edge-adjacent neighbours, d = sum of the 4 diagonals.
  - Identity: c.
  - Gaussian: (4c + 2n + d) >> 4. Truncating, 10-bit intermediate, never exceeds M.
  - Sharpen: 5c - n. Signed 10-bit intermediate, clamped to [0, M].
  - Edge: |4c - n|. Clamped to M.
- **Reset.** Asynchronous assertion clears all window, pipeline and primed state. Every output resets to 0 and data_valid_out to 0. After deassertion, the block re-primes from the next valid column. In-flight pixels are discarded.

## Timing
- Three register stages: window shift, partial sums, clamp/mux/output register.
- A valid column sampled on edge k yields its output, registered on edge k+2, visible in the cycle after that edge. Input-valid cycle t gives output-valid cycle t+3.
- No backpressure. Back-to-back valids sustain one pixel per cycle.
- Gaps in data_valid_in propagate unchanged, delayed 3 cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
Bench runs at HRES=8, VRES=4.
- **Identity ramp.** Identity, column_in[1] = {h, h, h}-encoded ramp on every line. Required: pixel_out equals the centre pixel, hcount_out = h-1, data_valid_out exactly 3 cycles after each input valid.
- **Gaussian flat field.** Gaussian, all rows 0x8410 on interior lines. Required: interior pixel_out = 0x8410.
- **Sharpen single dot.** Sharpen, centre pixel 0xFFFF at (3,1), all neighbours 0x0000. Required:
  - (3,1) outputs 0xFFFF (clamped).
  - (2,1) and (4,1) output 0x0000 (negative result clamped).
- **Edge step.** Edge, left half 0x0000 and right half 0x0841 on a row. Required: an output of 0x0841 at the step column; 0x0000 in flat regions.
- **Border and wrap.** Input h=0 on line v. Required: the output carries hcount_out=7, vcount_out = v-1, and the unfiltered pixel, even with filter_sel_in=3. Pixels at vcount 0 and 3 are also unfiltered.
- **Reset mid-line.** Pull rst_in low at h=4 for 1 cycle. Required:
  - All outputs read 0 immediately.
  - No data_valid_out for the first two valid columns after release.
  - Normal output on the third column.
